// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control unit: a state machine drives the datapath selects,
// bounds every memory wait with a trap, and keeps cycle and retired-instruction counters.
module mc_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             alu_positive,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [7:0] wait_q;
    logic       timed_out;
    logic       waiting;
    logic       retire;

    // funct is decoded by the ALU control, not by this FSM
    logic unused_funct;
    assign unused_funct = ^funct;

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timed_out = !mem_ready && (wait_q == WAIT_LAST);

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    code_d  = 2'd2;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    6'h00:                      state_d = S_EXEC_R;
                    6'h23, 6'h2B:               state_d = S_MEM_ADDR;
                    6'h04, 6'h05, 6'h07:        state_d = S_BRANCH;
                    6'h02:                      state_d = S_JUMP;
                    6'h08, 6'h0A, 6'h0C, 6'h0D: state_d = S_EXEC_I;
                    default: begin
                        state_d = S_TRAP;
                        code_d  = 2'd1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                reg_dst   = 1'b1;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 2'd3;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (state_q == S_MEM_WR);
                if (mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    code_d  = 2'd2;
                end
            end
            S_WB_ALU: begin
                // IR still holds the instruction, so R-type vs immediate is read from it
                reg_write = 1'b1;
                reg_dst   = (opcode == 6'h00);
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                case (opcode)
                    6'h04:   pc_write = alu_zero;
                    6'h05:   pc_write = !alu_zero;
                    6'h07:   pc_write = alu_positive;
                    default: pc_write = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset holds FETCH; keep its fetch-side controls quiet until release.
        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            alu_src_b = 2'd0;
        end
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_MEM_WR) ||
                     (state_q == S_BRANCH) || (state_q == S_JUMP));

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            code_q      <= 2'd0;
            wait_q      <= 8'd0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            if (state_d != state_q)
                wait_q <= 8'd0;
            else if (waiting && !mem_ready)
                wait_q <= wait_q + 8'd1;
            if (state_q != S_TRAP)
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (retire)
                instret_cnt <= instret_cnt + CNT_ONE;
        end
    end

    assign state     = state_q;
    assign trap      = (state_q == S_TRAP);
    assign trap_code = code_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: default instance plus TIMEOUT=4 and CNT_W=4 instances,
// each cycle compared against hand-computed state and control values.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       alu_zero = 1'b0;
    logic       alu_positive = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_ready_t = 1'b0;

    logic        pc_write, ir_write, iord, alu_src_a, mem_req, mem_we, reg_write, reg_dst, mem_to_reg, trap;
    logic [1:0]  pc_src, alu_src_b, alu_op, trap_code;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        t_pc_write, t_ir_write, t_iord, t_alu_src_a, t_mem_req, t_mem_we, t_reg_write, t_reg_dst;
    logic        t_mem_to_reg, t_trap;
    logic [1:0]  t_pc_src, t_alu_src_b, t_alu_op, t_trap_code;
    logic [3:0]  t_state;
    logic [31:0] t_cycle_cnt, t_instret_cnt;

    logic        c_pc_write, c_ir_write, c_iord, c_alu_src_a, c_mem_req, c_mem_we, c_reg_write, c_reg_dst;
    logic        c_mem_to_reg, c_trap;
    logic [1:0]  c_pc_src, c_alu_src_b, c_alu_op, c_trap_code;
    logic [3:0]  c_state;
    logic [3:0]  c_cycle_cnt, c_instret_cnt;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .alu_positive(alu_positive), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .trap(trap), .trap_code(trap_code), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    mc_control #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .alu_positive(alu_positive), .mem_ready(mem_ready_t), .pc_write(t_pc_write), .pc_src(t_pc_src),
        .ir_write(t_ir_write), .iord(t_iord), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
        .alu_op(t_alu_op), .mem_req(t_mem_req), .mem_we(t_mem_we), .reg_write(t_reg_write),
        .reg_dst(t_reg_dst), .mem_to_reg(t_mem_to_reg), .trap(t_trap), .trap_code(t_trap_code),
        .state(t_state), .cycle_cnt(t_cycle_cnt), .instret_cnt(t_instret_cnt)
    );

    mc_control #(.CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .alu_positive(alu_positive), .mem_ready(mem_ready), .pc_write(c_pc_write), .pc_src(c_pc_src),
        .ir_write(c_ir_write), .iord(c_iord), .alu_src_a(c_alu_src_a), .alu_src_b(c_alu_src_b),
        .alu_op(c_alu_op), .mem_req(c_mem_req), .mem_we(c_mem_we), .reg_write(c_reg_write),
        .reg_dst(c_reg_dst), .mem_to_reg(c_mem_to_reg), .trap(c_trap), .trap_code(c_trap_code),
        .state(c_state), .cycle_cnt(c_cycle_cnt), .instret_cnt(c_instret_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives mem_ready per cycle from rdy and checks the state nibble list sts, one cycle each.
    task automatic run_seq(input string tag, input int n, input logic [63:0] sts, input logic [15:0] rdy);
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy[i];
            #1;
            check(tag, state, sts[4*i +: 4]);
            tick();
        end
    endtask

    task automatic do_reset(input bit full);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #2;
        if (full) begin
            check("rst_state", state, 0);
            check("rst_mem_req", mem_req, 1);
            check("rst_ir_write", ir_write, 0);
            check("rst_pc_write", pc_write, 0);
            check("rst_alu_src_b", alu_src_b, 0);
            check("rst_cycle", cycle_cnt, 0);
            check("rst_instret", instret_cnt, 0);
            check("rst_trap", trap, 0);
            check("rst_trap_code", trap_code, 0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset(1'b1);

        // add: FETCH -> DECODE -> EXEC_R -> WB_ALU -> FETCH
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
        #1;
        check("add_s0", state, 0);
        check("add_ir_write", ir_write, 1);
        check("add_pc_write", pc_write, 1);
        check("add_rw0", reg_write, 0);
        tick();
        check("add_s1", state, 1);
        check("dec_alu_src_b", alu_src_b, 3);
        check("add_rw1", reg_write, 0);
        tick();
        check("add_s2", state, 2);
        check("exr_alu_src_a", alu_src_a, 1);
        check("exr_alu_op", alu_op, 2);
        check("add_rw2", reg_write, 0);
        tick();
        check("add_s7", state, 7);
        check("wb_reg_write", reg_write, 1);
        check("wb_reg_dst", reg_dst, 1);
        check("wb_mem_to_reg", mem_to_reg, 0);
        tick();
        check("add_s0_end", state, 0);
        check("add_instret", instret_cnt, 1);
        check("add_cycle", cycle_cnt, 4);

        repeat (16) tick();
        check("cycle_20", cycle_cnt, 20);
        check("instret_5", instret_cnt, 5);
        check("cnt4_cycle_wrap", c_cycle_cnt, 4);
        check("cnt4_instret", c_instret_cnt, 5);

        // lw with three not-ready cycles in MEM_RD
        opcode = 6'h23;
        run_seq("lw_state", 7, 64'h0555_5410, 16'h0047);
        check("lw_wb_state", state, 8);
        check("lw_mem_to_reg", mem_to_reg, 1);
        check("lw_reg_write", reg_write, 1);
        check("lw_reg_dst", reg_dst, 0);
        tick();
        check("lw_end_state", state, 0);
        check("lw_instret", instret_cnt, 6);

        // bne not taken, then taken
        opcode = 6'h05; alu_zero = 1'b1;
        run_seq("bne_nt", 2, 64'h10, 16'h3);
        check("bne_nt_state", state, 9);
        check("bne_nt_pc_write", pc_write, 0);
        check("bne_pc_src", pc_src, 1);
        check("bne_alu_op", alu_op, 1);
        tick();
        alu_zero = 1'b0;
        run_seq("bne_t", 2, 64'h10, 16'h3);
        check("bne_t_pc_write", pc_write, 1);
        check("bne_t_pc_src", pc_src, 1);
        tick();

        // bgtz taken
        opcode = 6'h07; alu_positive = 1'b1;
        run_seq("bgtz", 2, 64'h10, 16'h3);
        check("bgtz_pc_write", pc_write, 1);
        tick();

        // jump
        opcode = 6'h02;
        run_seq("j", 2, 64'h10, 16'h3);
        check("j_state", state, 10);
        check("j_pc_write", pc_write, 1);
        check("j_pc_src", pc_src, 2);
        tick();
        check("j_instret", instret_cnt, 10);

        // addi writes rt
        opcode = 6'h08;
        run_seq("addi", 3, 64'h310, 16'h7);
        check("addi_wb_state", state, 7);
        check("addi_reg_dst", reg_dst, 0);
        tick();
        check("addi_instret", instret_cnt, 11);

        // sw, reset asserted mid-access
        opcode = 6'h2B;
        run_seq("sw", 3, 64'h410, 16'h7);
        mem_ready = 1'b0;
        #1;
        check("sw_state", state, 6);
        check("sw_mem_we", mem_we, 1);
        check("sw_iord", iord, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_mem_we", mem_we, 0);
        check("async_state", state, 0);
        check("async_instret", instret_cnt, 0);
        mem_ready = 1'b1;
        #1;
        check("async_ir_write", ir_write, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_mem_req", mem_req, 1);
        check("post_rst_ir_write", ir_write, 1);

        // illegal opcode traps and freezes
        do_reset(1'b0);
        opcode = 6'h3F;
        run_seq("ill", 2, 64'h10, 16'h3);
        check("ill_state", state, 15);
        check("ill_trap", trap, 1);
        check("ill_code", trap_code, 1);
        check("ill_mem_req", mem_req, 0);
        check("ill_cycle", cycle_cnt, 2);
        repeat (100) tick();
        check("ill_state_100", state, 15);
        check("ill_cycle_100", cycle_cnt, 2);
        check("ill_code_100", trap_code, 1);

        // TIMEOUT=4: fetch never answered
        do_reset(1'b0);
        mem_ready_t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_wait_state", t_state, 0);
            check("to_ir_write", t_ir_write, 0);
            tick();
        end
        check("to_state", t_state, 15);
        check("to_trap", t_trap, 1);
        check("to_code", t_trap_code, 2);

        // TIMEOUT=4: ready on the last allowed cycle completes normally
        do_reset(1'b0);
        mem_ready_t = 1'b0;
        repeat (3) tick();
        mem_ready_t = 1'b1;
        #1;
        check("edge_state", t_state, 0);
        check("edge_ir_write", t_ir_write, 1);
        tick();
        check("edge_decode", t_state, 1);
        check("edge_no_trap", t_trap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
